tile_port_mux: RTL and testbench

- Parametrised, registered successor to the tile's combinational port steering logic.
- Connects one tile core to NUM_PORTS neighbour links.
- Resolves NIL, ANY and LAST to a physical port, then locks that port for the whole transaction.
- Adds a neighbour "listen" input so send-to-ANY goes only to a neighbour that is actually reading; ANY contention is settled by round-robin arbitration.

---
 rtl/tile_port_mux.sv | 224 ++++++++++++++++++++++
 tb/tb_tile_port_mux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_port_mux.sv
// Registered port steering between one tile core and NUM_PORTS neighbour links.
// NIL/ANY/LAST codes resolve to a physical port that stays locked for the whole transaction.
module tile_port_mux #(
   parameter int NUM_PORTS = 4,
   parameter int WIDTH     = 11,
   parameter int STALL_W   = 8,
   parameter int SEL_W     = $clog2(NUM_PORTS + 3)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [SEL_W-1:0]           loc,
   input  logic                       send,
   input  logic [WIDTH-1:0]           send_data,
   output logic                       send_done,
   input  logic                       recv,
   output logic [WIDTH-1:0]           recv_data,
   output logic                       recv_valid,
   output logic [NUM_PORTS*WIDTH-1:0] port_send_data,
   output logic [NUM_PORTS-1:0]       port_send_ready,
   input  logic [NUM_PORTS-1:0]       port_send_done,
   input  logic [NUM_PORTS-1:0]       port_listen,
   output logic [NUM_PORTS-1:0]       port_recv_ready,
   input  logic [NUM_PORTS-1:0]       port_recv_valid,
   input  logic [NUM_PORTS*WIDTH-1:0] port_recv_data,
   output logic [SEL_W-1:0]           last_port,
   output logic [STALL_W-1:0]         stall_cycles,
   output logic                       proto_err
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [SEL_W-1:0] NIL_CODE  = SEL_W'(NUM_PORTS);
   localparam logic [SEL_W-1:0] ANY_CODE  = SEL_W'(NUM_PORTS + 1);
   localparam logic [SEL_W-1:0] LAST_CODE = SEL_W'(NUM_PORTS + 2);

   typedef enum logic [2:0] {
      IDLE,
      SEND_ANY,
      SEND,
      RECV_ANY,
      RECV,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        port_q, port_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [WIDTH-1:0]     recv_data_q, recv_data_d;
   logic [SEL_W-1:0]     last_port_q, last_port_d;
   logic [STALL_W-1:0]   stall_q, stall_d;
   logic                 proto_err_q, proto_err_d;
   logic                 send_done_q, send_done_d;
   logic                 recv_valid_q, recv_valid_d;
   logic [NUM_PORTS-1:0] port_send_ready_q, port_send_ready_d;
   logic [NUM_PORTS-1:0] port_recv_ready_q, port_recv_ready_d;

   logic                 loc_ok;
   logic [SEL_W-1:0]     eff_loc;
   logic                 is_nil;
   logic                 is_any;
   logic [PW:0]          pick_send;
   logic [PW:0]          pick_recv;
   logic [STALL_W-1:0]   stall_inc;

   // Round-robin search: MSB flags a hit, low bits hold the first requester at or after ptr.
   function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                           input logic [PW-1:0]        ptr);
      logic [PW:0] res;
      int          idx;
      res = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NUM_PORTS;
         if (req[idx]) res = {1'b1, PW'(idx)};
      end
      return res;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] grant);
      return PW'((int'(grant) + 1) % NUM_PORTS);
   endfunction

   always_comb begin
      state_d      = state_q;
      port_d       = port_q;
      rr_ptr_d     = rr_ptr_q;
      data_d       = data_q;
      recv_data_d  = recv_data_q;
      last_port_d  = last_port_q;
      stall_d      = stall_q;
      proto_err_d  = proto_err_q;
      send_done_d  = 1'b0;
      recv_valid_d = 1'b0;

      // Illegal codes fold into NIL; LAST defers to the register, which may itself be NIL.
      loc_ok  = (loc <= LAST_CODE);
      eff_loc = loc_ok ? loc : NIL_CODE;
      if (eff_loc == LAST_CODE) eff_loc = last_port_q;
      is_nil  = (eff_loc == NIL_CODE);
      is_any  = (eff_loc == ANY_CODE);

      pick_send = rr_pick(port_listen, rr_ptr_q);
      pick_recv = rr_pick(port_recv_valid, rr_ptr_q);
      stall_inc = (stall_q == '1) ? stall_q : stall_q + STALL_W'(1);

      case (state_q)
         IDLE: begin
            if (send || recv) begin
               stall_d = '0;
               if (!loc_ok || (send && recv)) proto_err_d = 1'b1;
               if (recv) begin
                  if (is_nil) begin
                     state_d      = DONE;
                     recv_valid_d = 1'b1;
                     recv_data_d  = '0;
                  end else if (is_any) begin
                     state_d = RECV_ANY;
                  end else begin
                     port_d  = PW'(eff_loc);
                     state_d = RECV;
                  end
               end else begin
                  data_d = send_data;
                  if (is_nil) begin
                     state_d     = DONE;
                     send_done_d = 1'b1;
                  end else if (is_any) begin
                     state_d = SEND_ANY;
                  end else begin
                     port_d  = PW'(eff_loc);
                     state_d = SEND;
                  end
               end
            end
         end
         SEND_ANY: begin
            if (pick_send[PW]) begin
               port_d   = pick_send[PW-1:0];
               rr_ptr_d = next_ptr(pick_send[PW-1:0]);
               state_d  = SEND;
            end else begin
               stall_d = stall_inc;
            end
         end
         SEND: begin
            if (port_send_done[port_q]) begin
               state_d     = DONE;
               send_done_d = 1'b1;
               last_port_d = SEL_W'(port_q);
            end else begin
               stall_d = stall_inc;
            end
         end
         RECV_ANY: begin
            if (pick_recv[PW]) begin
               port_d   = pick_recv[PW-1:0];
               rr_ptr_d = next_ptr(pick_recv[PW-1:0]);
               state_d  = RECV;
            end else begin
               stall_d = stall_inc;
            end
         end
         RECV: begin
            if (port_recv_valid[port_q]) begin
               state_d      = DONE;
               recv_valid_d = 1'b1;
               recv_data_d  = port_recv_data[int'(port_q)*WIDTH +: WIDTH];
               last_port_d  = SEL_W'(port_q);
            end else begin
               stall_d = stall_inc;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Ready strobes follow the next state so they are registered and strictly one-hot.
      port_send_ready_d = (state_d == SEND) ? (NUM_PORTS'(1) << port_d) : '0;
      port_recv_ready_d = (state_d == RECV) ? (NUM_PORTS'(1) << port_d) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         port_q            <= '0;
         rr_ptr_q          <= '0;
         data_q            <= '0;
         recv_data_q       <= '0;
         last_port_q       <= NIL_CODE;
         stall_q           <= '0;
         proto_err_q       <= 1'b0;
         send_done_q       <= 1'b0;
         recv_valid_q      <= 1'b0;
         port_send_ready_q <= '0;
         port_recv_ready_q <= '0;
      end else begin
         state_q           <= state_d;
         port_q            <= port_d;
         rr_ptr_q          <= rr_ptr_d;
         data_q            <= data_d;
         recv_data_q       <= recv_data_d;
         last_port_q       <= last_port_d;
         stall_q           <= stall_d;
         proto_err_q       <= proto_err_d;
         send_done_q       <= send_done_d;
         recv_valid_q      <= recv_valid_d;
         port_send_ready_q <= port_send_ready_d;
         port_recv_ready_q <= port_recv_ready_d;
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_tx
      assign port_send_data[p*WIDTH +: WIDTH] = port_send_ready_q[p] ? data_q : '0;
   end

   assign send_done       = send_done_q;
   assign recv_data       = recv_data_q;
   assign recv_valid      = recv_valid_q;
   assign port_send_ready = port_send_ready_q;
   assign port_recv_ready = port_recv_ready_q;
   assign last_port       = last_port_q;
   assign stall_cycles    = stall_q;
   assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_tile_port_mux.sv
// Directed bench for tile_port_mux: a default instance plus a STALL_W=2 instance
// sharing the same inputs so counter saturation can be observed alongside.
module tb_tile_port_mux;

   localparam int NP = 4;
   localparam int W  = 11;
   localparam int SW = 3;
   localparam logic [SW-1:0] NIL  = 3'd4;
   localparam logic [SW-1:0] ANY  = 3'd5;
   localparam logic [SW-1:0] LAST = 3'd6;

   logic            clk = 1'b0;
   logic            rst;
   logic [SW-1:0]   loc;
   logic            send;
   logic [W-1:0]    send_data;
   logic            recv;
   logic [NP-1:0]   port_send_done;
   logic [NP-1:0]   port_listen;
   logic [NP-1:0]   port_recv_valid;
   logic [NP*W-1:0] port_recv_data;

   logic            send_done, recv_valid, proto_err;
   logic [W-1:0]    recv_data;
   logic [NP*W-1:0] port_send_data;
   logic [NP-1:0]   port_send_ready, port_recv_ready;
   logic [SW-1:0]   last_port;
   logic [7:0]      stall_cycles;

   logic            s_send_done, s_recv_valid, s_proto_err;
   logic [W-1:0]    s_recv_data;
   logic [NP*W-1:0] s_port_send_data;
   logic [NP-1:0]   s_port_send_ready, s_port_recv_ready;
   logic [SW-1:0]   s_last_port;
   logic [1:0]      s_stall_cycles;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   tile_port_mux dut (
      .clk(clk), .rst(rst), .loc(loc), .send(send), .send_data(send_data),
      .send_done(send_done), .recv(recv), .recv_data(recv_data), .recv_valid(recv_valid),
      .port_send_data(port_send_data), .port_send_ready(port_send_ready),
      .port_send_done(port_send_done), .port_listen(port_listen),
      .port_recv_ready(port_recv_ready), .port_recv_valid(port_recv_valid),
      .port_recv_data(port_recv_data), .last_port(last_port),
      .stall_cycles(stall_cycles), .proto_err(proto_err)
   );

   tile_port_mux #(.STALL_W(2)) dut_s (
      .clk(clk), .rst(rst), .loc(loc), .send(send), .send_data(send_data),
      .send_done(s_send_done), .recv(recv), .recv_data(s_recv_data), .recv_valid(s_recv_valid),
      .port_send_data(s_port_send_data), .port_send_ready(s_port_send_ready),
      .port_send_done(port_send_done), .port_listen(port_listen),
      .port_recv_ready(s_port_recv_ready), .port_recv_valid(port_recv_valid),
      .port_recv_data(port_recv_data), .last_port(s_last_port),
      .stall_cycles(s_stall_cycles), .proto_err(s_proto_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic r, input logic [SW-1:0] l,
                                input logic [W-1:0] d);
      send      = s;
      recv      = r;
      loc       = l;
      send_data = d;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst             = 1'b1;
      port_send_done  = '0;
      port_listen     = '0;
      port_recv_valid = '0;
      port_recv_data  = {11'h7FF, 11'd100, 11'd7, 11'h7FB};
      applyStimulus(1'b0, 1'b0, NIL, '0);
      tick();
      tick();
      $display("[TB] reset state");
      checkOutput("rst_last_port", 64'(last_port), 64'(NIL));
      checkOutput("rst_send_done", 64'(send_done), 64'd0);
      checkOutput("rst_recv_valid", 64'(recv_valid), 64'd0);
      checkOutput("rst_proto_err", 64'(proto_err), 64'd0);
      checkOutput("rst_stall", 64'(stall_cycles), 64'd0);
      checkOutput("rst_ready", 64'({port_send_ready, port_recv_ready}), 64'd0);
      rst = 1'b0;

      $display("[TB] fixed-port send to DOWN");
      applyStimulus(1'b1, 1'b0, 3'd1, 11'd42);
      tick();
      checkOutput("t1_ready_c1", 64'(port_send_ready), 64'b0010);
      checkOutput("t1_data_c1", 64'(port_send_data), 64'(42) << 11);
      checkOutput("t1_done_c1", 64'(send_done), 64'd0);
      tick();
      checkOutput("t1_stall_c2", 64'(stall_cycles), 64'd1);
      tick();
      port_send_done = 4'b0010;
      tick();
      checkOutput("t1_done_c4", 64'(send_done), 64'd1);
      checkOutput("t1_ready_c4", 64'(port_send_ready), 64'd0);
      checkOutput("t1_last_port", 64'(last_port), 64'd1);
      checkOutput("t1_stall_c4", 64'(stall_cycles), 64'd2);
      applyStimulus(1'b0, 1'b0, NIL, '0);
      port_send_done = '0;
      tick();
      checkOutput("t1_done_pulse", 64'(send_done), 64'd0);

      $display("[TB] recv ANY round robin");
      port_recv_valid = 4'b0101;
      applyStimulus(1'b0, 1'b1, ANY, '0);
      tick();
      checkOutput("t2a_rdy_c1", 64'(port_recv_ready), 64'd0);
      tick();
      checkOutput("t2a_rdy_c2", 64'(port_recv_ready), 64'b0001);
      tick();
      checkOutput("t2a_valid", 64'(recv_valid), 64'd1);
      checkOutput("t2a_data", 64'(recv_data), 64'h7FB);
      checkOutput("t2a_last", 64'(last_port), 64'd0);
      checkOutput("t2a_stall", 64'(stall_cycles), 64'd0);
      applyStimulus(1'b0, 1'b0, NIL, '0);
      tick();
      checkOutput("t2a_hold", 64'(recv_data), 64'h7FB);
      applyStimulus(1'b0, 1'b1, ANY, '0);
      tick();
      tick();
      checkOutput("t2b_rdy", 64'(port_recv_ready), 64'b0100);
      tick();
      checkOutput("t2b_valid", 64'(recv_valid), 64'd1);
      checkOutput("t2b_data", 64'(recv_data), 64'd100);
      checkOutput("t2b_last", 64'(last_port), 64'd2);
      applyStimulus(1'b0, 1'b0, NIL, '0);
      port_recv_valid = '0;
      tick();

      $display("[TB] send ANY with late listener");
      applyStimulus(1'b1, 1'b0, ANY, 11'h7FD);
      for (int i = 0; i < 6; i++) tick();
      checkOutput("t3_no_ready", 64'(port_send_ready), 64'd0);
      checkOutput("t3_stall_wait", 64'(stall_cycles), 64'd5);
      port_listen = 4'b1000;
      tick();
      checkOutput("t3_ready", 64'(port_send_ready), 64'b1000);
      checkOutput("t3_data", 64'(port_send_data), 64'h7FD << 33);
      port_listen    = 4'b0001;
      port_send_done = 4'b1000;
      tick();
      checkOutput("t3_done", 64'(send_done), 64'd1);
      checkOutput("t3_stall", 64'(stall_cycles), 64'd5);
      checkOutput("t3_last", 64'(last_port), 64'd3);
      applyStimulus(1'b0, 1'b0, NIL, '0);
      port_listen    = '0;
      port_send_done = '0;
      tick();

      $display("[TB] send and recv together");
      port_recv_data  = {11'h7FF, 11'd55, 11'd7, 11'h7FB};
      port_recv_valid = 4'b0100;
      applyStimulus(1'b1, 1'b1, 3'd2, 11'd9);
      tick();
      checkOutput("t5_rrdy", 64'(port_recv_ready), 64'b0100);
      checkOutput("t5_srdy", 64'(port_send_ready), 64'd0);
      checkOutput("t5_err", 64'(proto_err), 64'd1);
      tick();
      checkOutput("t5_valid", 64'(recv_valid), 64'd1);
      checkOutput("t5_data", 64'(recv_data), 64'd55);
      checkOutput("t5_nodone", 64'(send_done), 64'd0);
      applyStimulus(1'b0, 1'b0, NIL, '0);
      port_recv_valid = '0;
      tick();
      checkOutput("t5_sticky", 64'(proto_err), 64'd1);

      $display("[TB] reset during long SEND stall");
      applyStimulus(1'b1, 1'b0, 3'd0, 11'd9);
      tick();
      checkOutput("t6_ready", 64'(port_send_ready), 64'b0001);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("t6_stall", 64'(stall_cycles), 64'd10);
      checkOutput("t6_stall_sat", 64'(s_stall_cycles), 64'd3);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, NIL, '0);
      tick();
      checkOutput("t6_rst_ready", 64'(port_send_ready), 64'd0);
      checkOutput("t6_rst_data", 64'(port_send_data), 64'd0);
      checkOutput("t6_rst_last", 64'(last_port), 64'(NIL));
      checkOutput("t6_rst_err", 64'(proto_err), 64'd0);
      checkOutput("t6_rst_stall", 64'(s_stall_cycles), 64'd0);
      rst = 1'b0;
      tick();
      checkOutput("t6_no_done", 64'(send_done), 64'd0);

      $display("[TB] LAST after reset behaves as NIL");
      port_recv_valid = 4'b1111;
      applyStimulus(1'b0, 1'b1, LAST, '0);
      tick();
      checkOutput("t4_valid", 64'(recv_valid), 64'd1);
      checkOutput("t4_data", 64'(recv_data), 64'd0);
      checkOutput("t4_rrdy", 64'(port_recv_ready), 64'd0);
      applyStimulus(1'b0, 1'b0, NIL, '0);
      tick();

      $display("[TB] LAST after a real transaction");
      applyStimulus(1'b0, 1'b1, 3'd1, '0);
      tick();
      tick();
      checkOutput("t7_data", 64'(recv_data), 64'd7);
      applyStimulus(1'b0, 1'b0, NIL, '0);
      port_recv_valid = '0;
      tick();
      applyStimulus(1'b1, 1'b0, LAST, 11'd33);
      tick();
      checkOutput("t7_ready", 64'(port_send_ready), 64'b0010);
      checkOutput("t7_sdata", 64'(port_send_data), 64'(33) << 11);
      port_send_done = 4'b0010;
      tick();
      checkOutput("t7_done", 64'(send_done), 64'd1);
      applyStimulus(1'b0, 1'b0, NIL, '0);
      port_send_done = '0;
      tick();

      $display("[TB] illegal location code");
      applyStimulus(1'b1, 1'b0, 3'd7, 11'd1);
      tick();
      checkOutput("t8_done", 64'(send_done), 64'd1);
      checkOutput("t8_ready", 64'(port_send_ready), 64'd0);
      checkOutput("t8_err", 64'(proto_err), 64'd1);
      applyStimulus(1'b0, 1'b0, NIL, '0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
